// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI encodings, loader states and a clog2 helper
package axi_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axi_burst_splitter.sv
// axi_burst_splitter: burst length, next address and remaining-word tracking for INCR bursts
module axi_burst_splitter
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH = 16,
  parameter int STRB_WIDTH = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [CNT_WIDTH-1:0]  remaining,
  output logic [8:0]            len,
  output logic                  final_burst
);
  localparam int AS = clog2(STRB_WIDTH);
  logic [ADDR_WIDTH:0] to_top;
  logic [8:0] rem_c;
  assign to_top = ({1'b1, {ADDR_WIDTH{1'b0}}} - {1'b0, addr}) >> AS;
  assign rem_c = remaining >= CNT_WIDTH'(MAX_BURST_LEN) ? 9'(MAX_BURST_LEN) : 9'(remaining);
  assign len = to_top >= (ADDR_WIDTH + 1)'(rem_c) ? rem_c : 9'(to_top);
  assign final_burst = remaining == CNT_WIDTH'(len);
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      remaining <= '0;
    end else if (load) begin
      addr <= base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
      remaining <= word_count;
    end else if (advance) begin
      addr <= addr + ADDR_WIDTH'(32'(len) << AS);
      remaining <= remaining - CNT_WIDTH'(len);
    end
  end
endmodule

// File: rtl/axi_pim_loader.sv
// axi_pim_loader: AXI4 write-burst master streaming words into the PIM array
module axi_pim_loader
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = 8,
  parameter int AXI_ID = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0] remaining;
  logic [8:0] len, beat;
  logic final_burst, load, advance, w_hs, unused_bid;
  axi_burst_splitter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH(CNT_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .MAX_BURST_LEN(MAX_BURST_LEN)
  ) u_split (
    .clk(clk),
    .rst(rst),
    .load(load),
    .advance(advance),
    .base_addr(base_addr),
    .word_count(word_count),
    .addr(addr),
    .remaining(remaining),
    .len(len),
    .final_burst(final_burst)
  );
  assign unused_bid = ^m_axi_bid;
  assign load = state == S_IDLE && start && !done;
  assign advance = state == S_B && m_axi_bvalid;
  assign w_hs = m_axi_wvalid && m_axi_wready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      beat <= '0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_nx;
      beat <= state == S_AW ? 9'd0 : beat + 9'(w_hs);
      done <= (load && word_count == '0) || (advance && final_burst);
      error <= load ? 1'b0 : error | (advance && m_axi_bresp != RESP_OKAY);
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = state == S_IDLE ? (load && word_count != '0 ? S_AW : S_IDLE) :
               state == S_AW   ? (m_axi_awready ? S_W : S_AW) :
               state == S_W    ? (w_hs && m_axi_wlast ? S_B : S_W) :
                                 (advance ? (final_burst ? S_IDLE : S_AW) : S_B);
  end
  assign busy = state != S_IDLE;
  assign m_axi_awvalid = state == S_AW;
  assign m_axi_awaddr = addr;
  assign m_axi_awlen = m_axi_awvalid ? 8'(len - 9'd1) : 8'd0;
  assign m_axi_awid = ID_WIDTH'(AXI_ID);
  assign m_axi_awsize = 3'(clog2(STRB_WIDTH));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot = 3'b000;
  assign m_axi_wdata = s_axis_tdata;
  assign m_axi_wstrb = '1;
  assign m_axi_wvalid = state == S_W && s_axis_tvalid;
  assign s_axis_tready = state == S_W && m_axi_wready;
  assign m_axi_wlast = state == S_W && beat == len - 9'd1;
  assign m_axi_bready = state == S_B;
endmodule

// File: tb/tb_axi_pim_loader.sv
// tb_axi_pim_loader: directed checks of the loader against a small AXI slave and stream model
module tb_axi_pim_loader;
  import axi_pkg::*;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] base_addr = 0;
  logic [15:0] word_count = 0;
  logic busy, done, error;
  logic [31:0] s_axis_tdata;
  logic s_axis_tvalid, s_axis_tready;
  logic [7:0] m_axi_awid, m_axi_awaddr, m_axi_awlen;
  logic [2:0] m_axi_awsize, m_axi_awprot;
  logic [1:0] m_axi_awburst;
  logic m_axi_awlock, m_axi_awvalid, m_axi_awready;
  logic [3:0] m_axi_awcache, m_axi_wstrb;
  logic [31:0] m_axi_wdata;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [7:0] m_axi_bid;
  logic [1:0] m_axi_bresp;
  logic m_axi_bvalid, m_axi_bready;
  axi_pim_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int wlast_cnt, done_cnt, done_at, b_at, b_pend, viol, cyc;
  logic [31:0] sq[$];
  logic [15:0] aw_q[$];
  logic [31:0] w_q[$];
  logic [1:0] resp_q[$];
  logic [31:0] mem[64];
  logic [31:0] last_data;
  logic [7:0] cur_addr;
  bit stall = 0, wr_block = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [7:0] a, input logic [15:0] n);
    @(negedge clk);
    base_addr = a;
    word_count = n;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string tag);
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      #2;
    end
    chk({tag, " done"}, 32'(done), 1);
  endtask
  task automatic clear();
    aw_q.delete();
    w_q.delete();
    wlast_cnt = 0;
    done_cnt = 0;
    viol = 0;
  endtask
  task automatic chk_order(input string tag, input int n, input logic [31:0] first);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) if (i >= w_q.size() || w_q[i] !== first + 32'(i)) bad++;
    chk({tag, " beats"}, 32'(w_q.size()), 32'(n));
    chk({tag, " order"}, 32'(bad), 0);
  endtask
  initial begin
    s_axis_tvalid = 0;
    s_axis_tdata = 0;
    m_axi_awready = 1;
    m_axi_wready = 0;
    m_axi_bvalid = 0;
    m_axi_bresp = 0;
    m_axi_bid = 0;
    forever begin
      @(negedge clk);
      cyc++;
      m_axi_wready = wr_block ? 1'b0 : stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tvalid = sq.size() > 0 && (!stall || $urandom_range(0, 1) == 1);
      s_axis_tdata = sq.size() > 0 ? sq[0] : 32'd0;
      m_axi_bvalid = b_pend > 0;
      m_axi_bresp = resp_q.size() > 0 ? resp_q[0] : RESP_OKAY;
      #1;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_q.push_back({m_axi_awaddr, m_axi_awlen});
        cur_addr = m_axi_awaddr;
      end
      if (m_axi_wvalid && !s_axis_tvalid) viol++;
      if (m_axi_wvalid && m_axi_wready) begin
        w_q.push_back(m_axi_wdata);
        mem[cur_addr[7:2]] = m_axi_wdata;
        cur_addr = cur_addr + 8'd4;
        sq.delete(0);
        if (m_axi_wlast) begin
          wlast_cnt++;
          b_pend++;
          last_data = m_axi_wdata;
        end
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend--;
        if (resp_q.size() > 0) resp_q.delete(0);
        b_at = cyc;
      end
      if (done) begin
        done_cnt++;
        done_at = cyc;
      end
    end
  end
  initial begin
    foreach (mem[i]) mem[i] = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst busy/done/error", {busy, done, error}, 0);
    chk("rst valids/readys", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready}, 0);
    chk("rst awaddr/awlen", {m_axi_awaddr, m_axi_awlen}, 0);
    chk("constants", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_wstrb},
        {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'hf});
    rst = 0;
    clear();
    sq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    go(8'h00, 16'd4);
    chk("t1 awvalid/busy N+1", {m_axi_awvalid, busy}, 2'b11);
    chk("t1 aw fields", {m_axi_awaddr, m_axi_awlen}, 16'h0003);
    wait_done("t1");
    chk("t1 busy at done", 32'(busy), 0);
    chk("t1 done after B", 32'(done_at), 32'(b_at + 1));
    chk("t1 bursts", 32'(aw_q.size()), 1);
    chk("t1 mem", {mem[0][7:0], mem[1][7:0], mem[2][7:0], mem[3][7:0]}, 32'hA0A1A2A3);
    chk("t1 wlast data", last_data, 32'hA3);
    chk("t1 wlast count", 32'(wlast_cnt), 1);
    chk("t1 error", 32'(error), 0);
    clear();
    for (int i = 0; i < 40; i++) sq.push_back(32'h100 + 32'(i));
    go(8'h00, 16'd40);
    word_count = 16'd5;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("t2");
    chk("t2 bursts", 32'(aw_q.size()), 3);
    chk("t2 aw0", 32'(aw_q[0]), 32'h000F);
    chk("t2 aw1", 32'(aw_q[1]), 32'h400F);
    chk("t2 aw2", 32'(aw_q[2]), 32'h8007);
    chk_order("t2", 40, 32'h100);
    chk("t2 wlast count", 32'(wlast_cnt), 3);
    repeat (3) @(negedge clk);
    #2;
    chk("t2 single done", 32'(done_cnt), 1);
    clear();
    for (int i = 0; i < 8; i++) sq.push_back(32'hC0 + 32'(i));
    go(8'hF0, 16'd8);
    wait_done("t3");
    chk("t3 bursts", 32'(aw_q.size()), 2);
    chk("t3 aw0", 32'(aw_q[0]), 32'hF003);
    chk("t3 aw1", 32'(aw_q[1]), 32'h0003);
    chk("t3 mem top", {mem[60][7:0], mem[63][7:0]}, 16'hC0C3);
    chk("t3 mem wrap", {mem[0][7:0], mem[3][7:0]}, 16'hC4C7);
    clear();
    stall = 1;
    for (int i = 0; i < 20; i++) sq.push_back(32'h200 + 32'(i));
    go(8'h10, 16'd20);
    wait_done("t4");
    stall = 0;
    chk("t4 bursts", 32'(aw_q.size()), 2);
    chk("t4 aw0", 32'(aw_q[0]), 32'h100F);
    chk("t4 aw1", 32'(aw_q[1]), 32'h5003);
    chk_order("t4", 20, 32'h200);
    chk("t4 wvalid without tvalid", 32'(viol), 0);
    chk("t4 stream drained", 32'(sq.size()), 0);
    clear();
    resp_q = '{RESP_OKAY, RESP_SLVERR, RESP_OKAY};
    for (int i = 0; i < 40; i++) sq.push_back(32'h300 + 32'(i));
    go(8'h00, 16'd40);
    wait_done("t5");
    chk("t5 error at done", 32'(error), 1);
    chk("t5 bursts", 32'(aw_q.size()), 3);
    repeat (3) @(negedge clk);
    #2;
    chk("t5 error sticky", 32'(error), 1);
    clear();
    go(8'h00, 16'd0);
    #2;
    chk("t6 zero done N+1", 32'(done), 1);
    chk("t6 zero busy", 32'(busy), 0);
    chk("t6 error cleared", 32'(error), 0);
    @(negedge clk);
    #2;
    chk("t6 done pulse", 32'(done), 0);
    chk("t6 no aw", 32'(aw_q.size()), 0);
    clear();
    wr_block = 1;
    sq = '{32'h55, 32'h66};
    go(8'h20, 16'd4);
    @(negedge clk);
    #2;
    chk("t7 in W", {busy, m_axi_wvalid}, 2'b11);
    rst = 1;
    @(negedge clk);
    #2;
    chk("t7 rst busy/done/error", {busy, done, error}, 0);
    chk("t7 rst valids/readys", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready}, 0);
    chk("t7 rst awaddr/awlen", {m_axi_awaddr, m_axi_awlen}, 0);
    rst = 0;
    wr_block = 0;
    sq.delete();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
